rr_mux_arbiter: RTL
===================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels; legal range 2..16.
REQ-002 SHALL have parameter W, default 4: data width per channel.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ip_valid, input, N bits: per-channel request.
REQ-006 SHALL have port ip, input, N x W packed (channel i at bits i*W+:W): per-channel data.
REQ-007 SHALL have port ip_ready, output, N bits: per-channel accept; at most one bit high per cycle.
REQ-008 SHALL have port out, output, W bits: registered selected data.
REQ-009 SHALL have port sel, output, clog2(N) bits: index of the channel that produced the current out.
REQ-010 SHALL have port out_valid, output, 1 bit: out/sel hold a valid beat.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-012 SHALL hold one output register stage; load enable = !out_valid || out_ready.
REQ-013 SHALL hold a round-robin pointer ptr, clog2(N) bits; search order ptr, ptr+1, ..., wrapping from N-1 to 0.
REQ-014 SHALL grant the first channel in search order with ip_valid high; grant is combinational from the current ip_valid and ptr.
REQ-015 SHALL drive ip_ready[g] high only for grant g, and only when load enable is high; all other bits low.
REQ-016 SHALL, on a transfer (ip_valid[g] && ip_ready[g]), load out <= ip[g], sel <= g, out_valid <= 1, and ptr <= (g+1) mod N.
REQ-017 SHALL have a latency of 1 cycle, from the input transfer edge to out_valid high.
REQ-018 SHALL clear out_valid when out_valid && out_ready and no input transfer occurs in that cycle.
REQ-019 SHALL allow a simultaneous output pop and input transfer in the same cycle, sustaining 1 beat/cycle.
REQ-020 SHALL keep out, sel and out_valid unchanged while out_valid && !out_ready, with all ip_ready bits low.
REQ-021 SHALL leave ptr unchanged in any cycle with no transfer.
REQ-022 SHALL drive all ip_ready bits low when no ip_valid bit is high; there are no X-dependent outputs.
REQ-023 SHALL not make ip_ready depend combinationally on ip data, only on ip_valid, ptr, out_valid and out_ready.

Reset
REQ-024 SHALL, while rst is high at a clock edge, set out_valid=0, out=0, sel=0 and ptr=0.
REQ-025 SHALL drop the held beat if rst is asserted while out_valid && !out_ready; no transfer is recorded in that cycle.
REQ-026 SHALL drive ip_ready all-zero in every cycle where rst is high.

Configuration
REQ-027 SHALL use macro RR_MUX_ARBITER_PKT_LOCK_EN; when it is defined, the module adds input ports ip_last (N bits) and output port out_last (1 bit, registered alongside out).
REQ-028 SHALL, with the macro defined, lock the grant to channel g after a transfer with ip_last[g]=0; ptr is not advanced until a transfer with ip_last[g]=1, then ptr <= (g+1) mod N.
REQ-029 SHALL, with the macro defined, grant only the locked channel while locked, even if other channels are valid; rst clears the lock.
REQ-030 SHALL, without the macro, omit the ip_last/out_last ports and lock logic, and arbitrate on every beat.

Verification (N=4, W=4)
REQ-031 SHALL cover: ip_valid=4'b1111, ip={D,C,B,A}, out_ready=1 held -> out sequence A,B,C,D,A with sel 0,1,2,3,0, one beat per cycle from the cycle after the first transfer.
REQ-032 SHALL cover: ip_valid=4'b1000 with ptr=0 -> grant 3, out=ip[3], sel=3; the next grant search starts at 0 (wrap).
REQ-033 SHALL cover: out_valid=1 with out_ready=0 held for 3 cycles, ip changing -> out/sel stable, ip_ready=4'b0000; on out_ready=1 the next beat loads on the same edge.
REQ-034 SHALL cover: rst pulsed for 1 cycle mid-stream with out_valid=1 -> next cycle out_valid=0, out=0, sel=0; the first grant after reset is the lowest valid channel.
REQ-035 SHALL cover, with RR_MUX_ARBITER_PKT_LOCK_EN: ch1 sends 3 beats (ip_last=0,0,1) while ch2 is valid -> all 3 ch1 beats are delivered consecutively, then ch2 is granted.
REQ-036 SHALL cover: ip_valid=4'b0000 -> ip_ready=0, and out_valid falls after the last beat is popped.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin N-to-1 multiplexing arbiter with a single registered output stage.
// Optional packet locking is enabled by defining RR_MUX_ARBITER_PKT_LOCK_EN.
module rr_mux_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           ip_valid,
    input  logic [N*W-1:0]         ip,
    output logic [N-1:0]           ip_ready,
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    input  logic [N-1:0]           ip_last,
    output logic                   out_last,
`endif
    output logic [W-1:0]           out,
    output logic [$clog2(N)-1:0]   sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int SW = $clog2(N);
    localparam logic [SW:0]   NV     = (SW+1)'(N);
    localparam logic [SW-1:0] LASTCH = SW'(N-1);

    logic [SW-1:0]  r_ptr;
    logic [W-1:0]   r_out;
    logic [SW-1:0]  r_sel;
    logic           r_outValid;

    logic           w_loadEn;
    logic [2*N-1:0] w_validDbl;
    logic [N-1:0]   w_rot;
    logic           w_rrHit;
    logic [SW-1:0]  w_rrOff;
    logic [SW:0]    w_sum;
    logic [SW-1:0]  w_rrIdx;
    logic           w_grantHit;
    logic [SW-1:0]  w_grantIdx;
    logic [W-1:0]   w_grantData;
    logic           w_transfer;
    logic           w_advance;
    logic [SW-1:0]  w_ptrInc;

    assign w_loadEn   = (!r_outValid || out_ready) && !rst;
    assign w_validDbl = {ip_valid, ip_valid};
    assign w_rot      = N'(w_validDbl >> r_ptr);

    // Rotate requests so ptr sits at bit 0, then the lowest set bit is the winner.
    always_comb begin
        w_rrHit = 1'b0;
        w_rrOff = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_rrHit = 1'b1;
                w_rrOff = SW'(k);
            end
        end
    end

    assign w_sum   = {1'b0, r_ptr} + {1'b0, w_rrOff};
    assign w_rrIdx = (w_sum >= NV) ? SW'(w_sum - NV) : w_sum[SW-1:0];

`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lockState_t;

    lockState_t     r_lockState;
    lockState_t     w_lockStateNext;
    logic [SW-1:0]  r_lockCh;
    logic [SW-1:0]  w_lockChNext;
    logic           r_outLast;
    logic           w_grantLast;

    always_comb begin
        if (r_lockState == LOCK_HELD) begin
            w_grantHit = ip_valid[r_lockCh];
            w_grantIdx = r_lockCh;
        end else begin
            w_grantHit = w_rrHit;
            w_grantIdx = w_rrIdx;
        end
    end

    assign w_grantLast = ip_last[w_grantIdx];
    assign w_advance   = w_transfer && w_grantLast;

    always_comb begin
        w_lockStateNext = r_lockState;
        w_lockChNext    = r_lockCh;
        if (w_transfer) begin
            if (w_grantLast) begin
                w_lockStateNext = LOCK_IDLE;
            end else begin
                w_lockStateNext = LOCK_HELD;
                w_lockChNext    = w_grantIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockState <= LOCK_IDLE;
            r_lockCh    <= '0;
            r_outLast   <= 1'b0;
        end else begin
            r_lockState <= w_lockStateNext;
            r_lockCh    <= w_lockChNext;
            if (w_transfer) begin
                r_outLast <= w_grantLast;
            end
        end
    end

    assign out_last = r_outLast;
`else
    assign w_grantHit = w_rrHit;
    assign w_grantIdx = w_rrIdx;
    assign w_advance  = w_transfer;
`endif

    assign w_transfer = w_grantHit && w_loadEn;
    assign w_ptrInc   = (w_grantIdx == LASTCH) ? '0 : w_grantIdx + 1'b1;

    always_comb begin
        ip_ready = '0;
        if (w_transfer) begin
            ip_ready[w_grantIdx] = 1'b1;
        end
    end

    always_comb begin
        w_grantData = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grantIdx == SW'(i)) begin
                w_grantData = ip[i*W +: W];
            end
        end
    end

    // A pop with no simultaneous load empties the stage; a load always refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_sel      <= '0;
            r_outValid <= 1'b0;
            r_ptr      <= '0;
        end else begin
            if (w_transfer) begin
                r_out      <= w_grantData;
                r_sel      <= w_grantIdx;
                r_outValid <= 1'b1;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (w_advance) begin
                r_ptr <= w_ptrInc;
            end
        end
    end

    assign out       = r_out;
    assign sel       = r_sel;
    assign out_valid = r_outValid;

endmodule
